multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Multi-cycle signed 32-bit multiply/divide sequencer for the processor's ALU stage.
- Timeshares one instance of the team's 32-bit adder/subtractor, selected by opcode bit 0 (00000 = add, 00001 = subtract).
- Runs radix-2 Booth multiply, or restoring divide on magnitudes with sign fix-up.
- Issues a one-cycle result-ready pulse to the pipeline stall logic.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH

Ports:
clock  input  1  single clock, rising edge
reset  input  1  synchronous, active-high
ctrl_MULT  input  1  one-cycle start pulse, signed multiply
ctrl_DIV  input  1  one-cycle start pulse, signed divide
data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start edge
data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start edge
data_result  output  WIDTH  product low word or quotient; held until the next start
data_exception  output  1  overflow or divide-by-zero; valid when data_resultRDY=1, held with result
data_resultRDY  output  1  one-cycle pulse, result valid
busy  output  1  high from the edge after start through the fix-up edge

Behaviour:
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - state=IDLE, counter=0, all internal registers=0.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- Reset mid-operation: the operation is aborted, nothing is pulsed, and the block returns to IDLE on that edge.
- States and transitions:
  - IDLE: on a start pulse, go to MITER (multiply) or DNEGA (divide).
  - MITER (WIDTH cycles), then FIX.
  - DNEGA, then DNEGB, then DITER (WIDTH cycles), then FIX.
  - FIX: go to IDLE; registers the outputs and pulses data_resultRDY.
- Start arbitration:
  - ctrl_MULT and ctrl_DIV in the same cycle: MULT wins.
  - Start pulses while busy=1 are ignored.
  - A start is accepted in the same cycle that data_resultRDY is high.
- Latency, with the start sampled at edge E0:
  - Multiply: RDY is high in the cycle after edge E(WIDTH+1) (E33).
  - Divide: RDY is high after E(WIDTH+3) (E35).
  - Divide by zero (B==0): the check runs at E0, the block goes directly to FIX, and RDY is high after E1 with result=0 and exception=1.
- Multiply (Booth):
  - Register {P_hi, P_lo, q}: P_lo=B, P_hi=0, q=0; multiplicand M=A.
  - Each MITER cycle examines {P_lo[0], q}:
    - 01: P_hi+M (shared adder, opcode add).
    - 10: P_hi-M (shared adder, opcode subtract).
    - 00 or 11: no add.
  - Then an arithmetic shift right by 1 of {P_hi, P_lo, q}.
  - The shifted-in sign bit is sum[WIDTH-1] XOR adder overflow. This preserves correctness when the add overflows.
  - FIX: result=P_lo. exception=1 iff P_hi is not all copies of P_lo[WIDTH-1].
- Divide:
  - Sign handling:
    - DNEGA: a=|A| via the shared adder as 0-A, only when A[31]=1.
    - DNEGB: same for B into d.
    - qsign=A[31]^B[31].
  - DITER:
    - Remainder R is WIDTH+1 bits.
    - Shift {R, Q} left by 1; the trial is R-d.
    - The 33rd bit is resolved locally from the adder's sign and overflow.
    - If the trial is ≥0: R=trial and Q[0]=1; otherwise R is kept and Q[0]=0.
  - FIX:
    - Quotient truncates toward zero.
    - Negate Q via the shared adder if qsign=1.
    - exception=1 for 0x80000000 / 0xFFFFFFFF, with result=0.
    - The remainder is discarded.
- Adder sharing: the adder is owned by exactly one state per cycle. In IDLE the adder inputs are driven to 0.

Decomposition:
- Shared package `multdiv_pkg`:
  - state encoding constants.
  - ALU opcodes OP_ADD=5'b00000, OP_SUB=5'b00001.
  - WIDTH default.
- One sub-module, `multdiv_counter`: a 6-bit iteration counter with load/enable/terminal-count outputs.
- The adder/subtractor is instantiated once as the existing block, unchanged.

Test Plan:
- MULT A=7, B=0xFFFFFFFD (-3) -> RDY exactly after E33, result=0xFFFFFFEB, exception=0, busy low after RDY.
- MULT A=0x00010000, B=0x00010000 -> result=0x00000000, exception=1. MULT A=0x80000000, B=0xFFFFFFFF -> exception=1.
- DIV A=0xFFFFFFF9 (-7), B=2 -> RDY after E35, result=0xFFFFFFFD (-3), exception=0. DIV A=100, B=7 -> result=14.
- DIV A=100, B=0 -> RDY after E1, result=0, exception=1. DIV A=0x80000000, B=0xFFFFFFFF -> exception=1.
- Start MULT, assert reset at E10 -> no RDY ever, all outputs 0. A new DIV started after reset completes correctly.
- ctrl_MULT and ctrl_DIV together -> multiply performed. Operand changes and ctrl_DIV pulses mid-operation -> ignored, result unchanged.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: widths, ALU opcodes, FSM states.
package multdiv_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam int unsigned CNT_W    = 6;

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MITER = 3'd1,
        S_DNEGA = 3'd2,
        S_DNEGB = 3'd3,
        S_DITER = 3'd4,
        S_FIX   = 3'd5
    } state_t;

    // Opcode for the shared adder: subtract when sub=1, otherwise add.
    function automatic logic [4:0] addsub_op(input logic sub);
        return sub ? OP_SUB : OP_ADD;
    endfunction

endpackage

// File: rtl/alu_addsub.sv
// Existing ALU adder/subtractor: opcode bit 0 selects subtract; reports signed overflow.
module alu_addsub #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic [4:0]       ctrl_ALUopcode,
    output logic [WIDTH-1:0] data_result,
    output logic             overflow
);

    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic             unused_opcode_bits;

    assign sub                = ctrl_ALUopcode[0];
    assign unused_opcode_bits = ^ctrl_ALUopcode[4:1];

    // Two's-complement add of A and (optionally inverted) B with carry-in for subtract.
    always_comb begin
        b_eff       = sub ? ~data_operandB : data_operandB;
        data_result = data_operandA + b_eff + {{(WIDTH-1){1'b0}}, sub};
        overflow    = (data_operandA[WIDTH-1] == b_eff[WIDTH-1]) &&
                      (data_result[WIDTH-1] != data_operandA[WIDTH-1]);
    end

endmodule

// File: rtl/multdiv_counter.sv
// Down-counting iteration counter with synchronous load and terminal-count flag.
module multdiv_counter
    import multdiv_pkg::*;
#(
    parameter int unsigned CW = CNT_W
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] load_val_i,
    output logic          tc_o
);

    logic [CW-1:0] count_q, count_d;

    // Next count: load takes priority over decrement; saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_d = count_q - CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// sequencer sharing a single adder/subtractor with the ALU stage.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int unsigned WIDTH = MD_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] INT_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    state_t state_q, state_d;

    // acc: Booth P_hi / divide remainder.  lo: Booth P_lo / dividend-quotient.
    // mcd: multiplicand M / divisor magnitude d.
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] mcd_q, mcd_d;
    logic             bit_q, bit_d;
    logic             is_div_q, is_div_d;
    logic             qsign_q, qsign_d;
    logic             dz_q, dz_d;
    logic             dovf_q, dovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] add_a, add_b, add_sum;
    logic [4:0]       add_op;
    logic             add_ovf;

    logic             cnt_load, cnt_en, cnt_tc;

    logic [WIDTH-1:0] rsh_lo;
    logic             borrow, trial_ge;

    alu_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .data_operandA  (add_a),
        .data_operandB  (add_b),
        .ctrl_ALUopcode (add_op),
        .data_result    (add_sum),
        .overflow       (add_ovf)
    );

    multdiv_counter #(
        .CW (CNT_W)
    ) u_cnt (
        .clk_i      (clock),
        .rst_i      (reset),
        .load_i     (cnt_load),
        .en_i       (cnt_en),
        .load_val_i (ITER_LAST),
        .tc_o       (cnt_tc)
    );

    // Next-state, shared-adder steering and datapath updates for each FSM state.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        lo_d     = lo_q;
        mcd_d    = mcd_q;
        bit_d    = bit_q;
        is_div_d = is_div_q;
        qsign_d  = qsign_q;
        dz_d     = dz_q;
        dovf_d   = dovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        add_a    = '0;
        add_b    = '0;
        add_op   = OP_ADD;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        rsh_lo   = '0;
        borrow   = 1'b0;
        trial_ge = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (ctrl_MULT) begin
                    state_d  = S_MITER;
                    is_div_d = 1'b0;
                    acc_d    = '0;
                    lo_d     = data_operandB;
                    bit_d    = 1'b0;
                    mcd_d    = data_operandA;
                    qsign_d  = 1'b0;
                    dz_d     = 1'b0;
                    dovf_d   = 1'b0;
                    cnt_load = 1'b1;
                end else if (ctrl_DIV) begin
                    is_div_d = 1'b1;
                    acc_d    = '0;
                    lo_d     = data_operandA;
                    bit_d    = 1'b0;
                    mcd_d    = data_operandB;
                    qsign_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    dz_d     = (data_operandB == '0);
                    dovf_d   = (data_operandA == INT_MIN) && (data_operandB == '1);
                    state_d  = (data_operandB == '0) ? S_FIX : S_DNEGA;
                end
            end

            S_MITER: begin
                add_a = acc_q;
                unique case ({lo_q[0], bit_q})
                    2'b01:   add_b = mcd_q;
                    2'b10: begin
                        add_b  = mcd_q;
                        add_op = OP_SUB;
                    end
                    default: add_b = '0;
                endcase
                // Shifted-in sign is the true sign of the WIDTH+1-bit sum, so an
                // overflowing partial sum still shifts correctly.
                {acc_d, lo_d, bit_d} = {add_sum[WIDTH-1] ^ add_ovf, add_sum, lo_q};
                if (cnt_tc) begin
                    state_d = S_FIX;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            S_DNEGA: begin
                add_b  = lo_q;
                add_op = OP_SUB;
                if (lo_q[WIDTH-1]) begin
                    lo_d = add_sum;
                end
                state_d = S_DNEGB;
            end

            S_DNEGB: begin
                add_b  = mcd_q;
                add_op = OP_SUB;
                if (mcd_q[WIDTH-1]) begin
                    mcd_d = add_sum;
                end
                state_d  = S_DITER;
                cnt_load = 1'b1;
            end

            S_DITER: begin
                // Shifted remainder is {acc_q, lo_q[MSB]} (WIDTH+1 bits); its top bit
                // is acc_q[MSB]. The adder handles the low WIDTH bits and the unsigned
                // borrow is recovered from signed less-than (sign ^ overflow) by
                // correcting for the operand MSBs. Remainder always fits back in WIDTH.
                rsh_lo   = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
                add_a    = rsh_lo;
                add_b    = mcd_q;
                add_op   = OP_SUB;
                borrow   = (add_sum[WIDTH-1] ^ add_ovf) ^ rsh_lo[WIDTH-1] ^ mcd_q[WIDTH-1];
                trial_ge = acc_q[WIDTH-1] | ~borrow;
                if (trial_ge) begin
                    acc_d = add_sum;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rsh_lo;
                    lo_d  = {lo_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_tc) begin
                    state_d = S_FIX;
                end else begin
                    cnt_en = 1'b1;
                end
            end

            S_FIX: begin
                state_d = S_IDLE;
                rdy_d   = 1'b1;
                if (is_div_q) begin
                    add_b    = lo_q;
                    add_op   = addsub_op(qsign_q);
                    result_d = add_sum;
                    exc_d    = 1'b0;
                    if (dz_q || dovf_q) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end
                end else begin
                    result_d = lo_q;
                    exc_d    = (acc_q != {WIDTH{lo_q[WIDTH-1]}});
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers; reset clears everything, aborting any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc_q    <= '0;
            lo_q     <= '0;
            mcd_q    <= '0;
            bit_q    <= 1'b0;
            is_div_q <= 1'b0;
            qsign_q  <= 1'b0;
            dz_q     <= 1'b0;
            dovf_q   <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            lo_q     <= lo_d;
            mcd_q    <= mcd_d;
            bit_q    <= bit_d;
            is_div_q <= is_div_d;
            qsign_q  <= qsign_d;
            dz_q     <= dz_d;
            dovf_q   <= dovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl with an expected-result scoreboard.
module tb_multdiv_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic [31:0] last_res;

    multdiv_ctrl #(
        .WIDTH (32)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference arithmetic: 64-bit signed product, SV truncating division.
    function automatic exp_t model(input logic is_div, input logic [31:0] a,
                                   input logic [31:0] b, input string tag);
        exp_t        e;
        longint      p;
        logic [31:0] plo;
        int          q;
        e.tag = tag;
        if (!is_div) begin
            p     = longint'($signed(a)) * longint'($signed(b));
            plo   = p[31:0];
            e.res = plo;
            e.exc = (p != longint'($signed(plo)));
            e.lat = 33;
        end else if (b == 32'd0) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'd0;
            e.exc = 1'b1;
            e.lat = 35;
        end else begin
            q     = $signed(a) / $signed(b);
            e.res = q;
            e.exc = 1'b0;
            e.lat = 35;
        end
        return e;
    endfunction

    // Issue a start in the current cycle, scramble inputs while busy, wait for RDY and score it.
    task automatic run_op(input logic mul, input logic div, input logic [31:0] a,
                          input logic [31:0] b, input bit disturb, input string tag);
        exp_t e;
        int   k;
        bit   seen;
        sb.push_back(model(!mul, a, b, tag));
        ctrl_MULT     = mul;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom();
        data_operandB = $urandom();
        check32({tag, "_busy_start"}, 32'(busy), 32'd1);
        check32({tag, "_rdy_start"}, 32'(data_resultRDY), 32'd0);
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 40) begin
            k++;
            if (disturb && k == 4) ctrl_DIV = 1'b1;
            if (disturb && k == 6) ctrl_MULT = 1'b1;
            if (disturb && k == 9) begin
                ctrl_MULT = 1'b1;
                ctrl_DIV  = 1'b1;
            end
            @(posedge clock); #1;
            ctrl_MULT     = 1'b0;
            ctrl_DIV      = 1'b0;
            data_operandA = $urandom();
            data_operandB = $urandom();
            if (data_resultRDY === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        n_vec++;
        assert (seen) else begin
            n_err++;
            $error("FAIL %s_timeout: observed no data_resultRDY expected within 40 cycles", e.tag);
        end
        if (seen) begin
            check32({e.tag, "_latency"}, k, e.lat);
            check32({e.tag, "_result"}, data_result, e.res);
            check32({e.tag, "_exception"}, 32'(data_exception), 32'(e.exc));
            check32({e.tag, "_busy_rdy"}, 32'(busy), 32'd0);
        end
        last_res = e.res;
    endtask

    initial begin
        int hits;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check32("reset_result", data_result, 32'd0);
        check32("reset_exc", 32'(data_exception), 32'd0);
        check32("reset_rdy", 32'(data_resultRDY), 32'd0);
        check32("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;

        // Multiply
        run_op(1'b1, 1'b0, 32'd7,          32'hFFFF_FFFD, 1'b0, "mul_7xm3");
        run_op(1'b1, 1'b0, 32'h0001_0000,  32'h0001_0000, 1'b0, "mul_ovf_2p32");
        run_op(1'b1, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "mul_min_xm1");
        run_op(1'b1, 1'b0, 32'h8000_0000,  32'h8000_0000, 1'b0, "mul_min_xmin");
        run_op(1'b1, 1'b0, 32'hFFFF_FFF0,  32'hFFFF_FFF3, 1'b0, "mul_neg_neg");

        // Divide
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9,  32'd2,         1'b0, "div_m7_2");
        run_op(1'b0, 1'b1, 32'd100,        32'd7,         1'b0, "div_100_7");
        run_op(1'b0, 1'b1, 32'd100,        32'd0,         1'b0, "div_by_zero");
        run_op(1'b0, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 1'b0, "div_min_m1");
        run_op(1'b0, 1'b1, 32'hFFFF_FF9C,  32'd7,         1'b0, "div_m100_7");
        run_op(1'b0, 1'b1, 32'h8000_0000,  32'd3,         1'b0, "div_min_3");
        run_op(1'b0, 1'b1, 32'h7FFF_FFFF,  32'h8000_0000, 1'b0, "div_max_min");

        // Reset aborts an in-flight multiply
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd5;
        data_operandB = 32'd9;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check32("abort_result", data_result, 32'd0);
        check32("abort_exc", 32'(data_exception), 32'd0);
        check32("abort_rdy", 32'(data_resultRDY), 32'd0);
        check32("abort_busy", 32'(busy), 32'd0);
        hits = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY !== 1'b0) hits++;
        end
        check32("abort_no_rdy", hits, 32'd0);
        run_op(1'b0, 1'b1, 32'd1000, 32'hFFFF_FFF7, 1'b0, "div_after_abort");

        // Arbitration and ignored mid-operation starts
        run_op(1'b1, 1'b1, 32'd6,   32'hFFFF_FFFB, 1'b0, "both_start_mul");
        run_op(1'b0, 1'b1, 32'd100, 32'd7,         1'b1, "div_disturbed");
        run_op(1'b1, 1'b0, 32'd12345, 32'd678,     1'b1, "mul_disturbed");

        // Result/exception held, RDY stays low while idle
        repeat (3) begin
            @(posedge clock); #1;
            check32("hold_result", data_result, last_res);
            check32("hold_rdy", 32'(data_resultRDY), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
